reset_sync: RTL and testbench
=============================

# reset_sync

Reset bridge that turns an asynchronous, active-high reset into a reset for the `clk` domain. The reset asserts immediately and deasserts synchronously. It sits at the top of each clock domain and drives the resets of all downstream logic there. Deassertion is passed through a metastability-hardened flop chain and then stretched by a programmable number of cycles. A one-cycle "reset released" strobe marks the release.

## Interface
Clocking: one clock; reset is asynchronous and active-high.

Parameters:
- `SYNC_STAGES`, default 3: synchronizer flop count. Must be at least 2, otherwise elaboration fails.
- `STRETCH_CYCLES`, default 4: extra cycles held in reset after the chain releases. Must be at least 0.

Ports:
- `clk`  in  1: domain clock (32 MHz nominal, 31.25 ns period).
- `reset`  in  1: asynchronous active-high reset request. Any source, any width; glitches are accepted.
- `rst_out`  out  1: synchronized active-high reset.
- `rst_n_out`  out  1: always the exact complement of `rst_out`, driven from its own flop.
- `rst_done`  out  1: one-cycle strobe in the first cycle after `rst_out` falls.

All outputs may be left unconnected without warnings that break the build.

## Operation
- Asserting `reset` asynchronously sets the following, independent of `clk`:
  - all chain flops to 1;
  - the stretch counter to `STRETCH_CYCLES`;
  - `rst_out`=1, `rst_n_out`=0, `rst_done`=0.
- While `reset`=1, the outputs hold these values.
- Synchronizer chain: stage 0 samples constant 0, and each later stage samples the previous one. The chain output is the last stage.
- Stretch counter, width `max(1, $clog2(STRETCH_CYCLES+1))`:
  - Decrements by 1 on each rising edge where the chain output is 0 and the count is nonzero.
  - Saturates at 0, with no wrap.
- `rst_out` is registered. It is 1 while the chain output is 1 or the count is nonzero, so it does not glitch.
- `rst_done` goes high for exactly one cycle on the 1→0 transition of `rst_out`. It never fires while `reset` is high.
- Power-up: every flop has an initial/configuration value equal to its reset value. Outputs therefore come up asserted, and release by the normal sequence even if `reset` never pulses.
- Reset re-asserted mid-release, at any edge or between edges:
  - the outputs re-assert immediately;
  - the full sequence restarts from the beginning;
  - no `rst_done` is produced for the aborted release.
- No combinational path from `reset` to any output except through flop async set/clear pins.

## Timing
- Assertion latency: asynchronous, flop clock-to-out only, with no clock edges required.
- Deassertion: let E1 be the first rising edge at which `reset` is sampled 0.
  - The chain output falls after edge E`SYNC_STAGES`.
  - `rst_out` falls after edge E(`SYNC_STAGES`+`STRETCH_CYCLES`).
  - Defaults: `rst_out` falls after E7; `rst_done` is high from after E7 until after E8.
- With `STRETCH_CYCLES`=0, `rst_out` falls after E`SYNC_STAGES`.
- A `reset` pulse narrower than one clock period still produces a full assertion plus the full release sequence.

## Structure
- No shared package needed. The counter width is a localparam inside the module.
- One natural sub-module, `sync_chain_rst`: a parameterized N-flop chain with async set.
  - Reusable by other synchronizers.
  - Carries the vendor attributes (ASYNC_REG / dont-touch) on its flops.
- The top level holds the stretch counter and the output/strobe flops.

## Test plan
- Power-up with `reset`=0 held, defaults → `rst_out`=1 at time 0, falls after the 7th edge, `rst_done` pulses once, and there are no X values after t=0.
- Sequence: hold `reset`=0 for 5 cycles, then 1 for 5 cycles, then 0 → `rst_out`=1 within 1 ns of the rise, stays 1 through the pulse, and falls exactly 7 edges after the first low sample. `rst_n_out` is always its complement.
- A 5 ns `reset` pulse between clock edges after release → `rst_out` rises immediately, then releases 7 edges later with exactly one `rst_done`.
- `reset` re-asserted 3 edges into a release → immediate re-assert, no `rst_done`, and a full 7-edge release after the final deassert.
- `SYNC_STAGES`=2, `STRETCH_CYCLES`=0 → release after the 2nd edge.
- `SYNC_STAGES`=1 → elaboration error.

Source files
------------

// File: rtl/sync_chain_rst.sv
// N-flop synchronizer chain with an asynchronous set. Stage 0 samples a
// constant 0. The chain output therefore falls STAGES edges after the set is released.
module sync_chain_rst #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  output logic sync,
  output logic sync_next
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_chain_rst: STAGES must be at least 2");
    assign sync      = 1'b1;
    assign sync_next = 1'b1;
  end else begin : g_chain
    // Keep the flops adjacent and untouched so that their metastability settling time is preserved.
    (* ASYNC_REG = "TRUE", dont_touch = "true" *)
    logic [STAGES-1:0] chain_reg = '1;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        chain_reg <= '1;
      end else begin
        chain_reg <= {chain_reg[STAGES-2:0], 1'b0};
      end
    end

    assign sync      = chain_reg[STAGES-1];
    // sync_next lets the consumer register the value that sync takes after the next edge.
    assign sync_next = chain_reg[STAGES-2];
  end

endmodule

// File: rtl/reset_sync.sv
// Reset bridge: asserts asynchronously and releases through a synchronizer chain.
// The release is then stretched by STRETCH_CYCLES, and a one-cycle done strobe marks the release.
module reset_sync #(
  parameter int SYNC_STAGES    = 3,
  parameter int STRETCH_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  output logic rst_out,
  output logic rst_n_out,
  output logic rst_done
);

  localparam int CW = (STRETCH_CYCLES < 1) ? 1 : $clog2(STRETCH_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(STRETCH_CYCLES);

  if (STRETCH_CYCLES < 0) begin : g_bad_stretch
    $error("reset_sync: STRETCH_CYCLES must be at least 0");
  end

  logic sync;
  logic sync_next;

  sync_chain_rst #(
    .STAGES (SYNC_STAGES)
  ) u_chain (
    .clk       (clk),
    .rst       (reset),
    .sync      (sync),
    .sync_next (sync_next)
  );

  logic [CW-1:0] count_reg   = COUNT_INIT;
  logic          rst_out_reg = 1'b1;
  logic          rst_n_reg   = 1'b0;
  logic          done_reg    = 1'b0;
  logic [CW-1:0] count_next;
  logic          rst_out_next;

  // The outputs are computed from next-state values, so rst_out falls on the same edge as the counter reaching zero.
  always_comb begin
    count_next = count_reg;
    if (!sync && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
    rst_out_next = sync_next | (count_next != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg   <= COUNT_INIT;
      rst_out_reg <= 1'b1;
      rst_n_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      count_reg   <= count_next;
      rst_out_reg <= rst_out_next;
      rst_n_reg   <= ~rst_out_next;
      done_reg    <= rst_out_reg & ~rst_out_next;
    end
  end

  assign rst_out   = rst_out_reg;
  assign rst_n_out = rst_n_reg;
  assign rst_done  = done_reg;

endmodule

// File: tb/tb_reset_sync.sv
// Bench for reset_sync: a default instance (3/4) and a minimal instance (2/0) share clk and reset.
// A release-count reference model checks both instances every cycle, alongside table and hand-written sequences.
`timescale 1ns/1ps
module tb_reset_sync;

  localparam int REL_A = 7;  // 3 sync stages + 4 stretch cycles
  localparam int REL_B = 2;  // 2 sync stages + 0 stretch cycles

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rst_out_a, rst_n_out_a, rst_done_a;
  logic rst_out_b, rst_n_out_b, rst_done_b;

  int tests = 0;
  int fails = 0;

  always #15.625 clk = ~clk;

  reset_sync dut_a (
    .clk       (clk),
    .reset     (reset),
    .rst_out   (rst_out_a),
    .rst_n_out (rst_n_out_a),
    .rst_done  (rst_done_a)
  );

  reset_sync #(.SYNC_STAGES(2), .STRETCH_CYCLES(0)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .rst_out   (rst_out_b),
    .rst_n_out (rst_n_out_b),
    .rst_done  (rst_done_b)
  );

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: 'lows' counts consecutive edges that sampled reset low with no pulse in between.
  // The output stays in reset until that count reaches the release length, and the done strobe marks exactly that count.
  int lows = 0;
  bit seen = 1'b0;

  always @(posedge reset) seen = 1'b1;

  always @(posedge clk) begin
    if (reset) lows = 0;
    else if (seen) lows = 1;
    else if (lows < 1000) lows++;
    seen = 1'b0;
  end

  always @(negedge clk) begin
    logic held;
    held = reset || seen;
    check("mon_rst_out_a", rst_out_a, held || (lows < REL_A));
    check("mon_rst_n_a",   rst_n_out_a, !(held || (lows < REL_A)));
    check("mon_done_a",    rst_done_a, !held && (lows == REL_A));
    check("mon_rst_out_b", rst_out_b, held || (lows < REL_B));
    check("mon_rst_n_b",   rst_n_out_b, !(held || (lows < REL_B)));
    check("mon_done_b",    rst_done_b, !held && (lows == REL_B));
    $display("[TB] t=%0t reset=%b lows=%0d a:%b%b%b b:%b%b%b", $time, reset, lows,
             rst_out_a, rst_n_out_a, rst_done_a, rst_out_b, rst_n_out_b, rst_done_b);
  end

  // Counts the edges from E1 until each rst_out falls, plus the number of done strobes seen in the same window.
  task automatic measure_release(input string tag);
    int fall_a = 0, fall_b = 0, done_a = 0, done_b = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (fall_a == 0 && rst_out_a === 1'b0) fall_a = e;
      if (fall_b == 0 && rst_out_b === 1'b0) fall_b = e;
      if (rst_done_a === 1'b1) done_a++;
      if (rst_done_b === 1'b1) done_b++;
    end
    check_int({tag, "_fall_a"}, fall_a, REL_A);
    check_int({tag, "_fall_b"}, fall_b, REL_B);
    check_int({tag, "_done_a"}, done_a, 1);
    check_int({tag, "_done_b"}, done_b, 1);
  endtask

  task automatic check_asserted(input string tag);
    check({tag, "_imm_a"},   rst_out_a, 1'b1);
    check({tag, "_imm_n_a"}, rst_n_out_a, 1'b0);
    check({tag, "_imm_b"},   rst_out_b, 1'b1);
    check({tag, "_imm_d_a"}, rst_done_a, 1'b0);
  endtask

  typedef struct {
    int hold_cycles;  // 0 selects a sub-cycle pulse of pulse_ns width
    int pulse_ns;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{5, 0};
    vecs[1] = '{0, 5};
    vecs[2] = '{1, 0};
    vecs[3] = '{12, 0};
    vecs[4] = '{0, 1};

    // Power-up with reset never asserted
    #1;
    check("pwr_rst_out_a", rst_out_a, 1'b1);
    check("pwr_rst_n_a",   rst_n_out_a, 1'b0);
    check("pwr_done_a",    rst_done_a, 1'b0);
    check("pwr_rst_out_b", rst_out_b, 1'b1);
    measure_release("pwr");

    // Table-driven assertion patterns
    for (int i = 0; i < 5; i++) begin
      repeat (5) @(negedge clk);
      #3 reset = 1'b1;
      #1 check_asserted($sformatf("vec%0d", i));
      if (vecs[i].hold_cycles == 0) begin
        #(vecs[i].pulse_ns) reset = 1'b0;
      end else begin
        repeat (vecs[i].hold_cycles) @(negedge clk);
        #3 reset = 1'b0;
      end
      measure_release($sformatf("vec%0d", i));
    end

    // Re-assertion three edges into a release aborts it without a strobe.
    @(negedge clk);
    #3 reset = 1'b1;
    repeat (2) @(negedge clk);
    #3 reset = 1'b0;
    begin
      int done_a = 0;
      for (int e = 1; e <= 3; e++) begin
        @(posedge clk);
        #1;
        if (rst_done_a === 1'b1) done_a++;
      end
      #4 reset = 1'b1;
      #1 check_asserted("abort");
      repeat (2) @(negedge clk);
      check_int("abort_no_done", done_a, 0);
      #3 reset = 1'b0;
      measure_release("abort");
    end

    // Randomized pulses and holds; the monitor checks every cycle.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 10)) @(negedge clk);
      @(negedge clk);
      if ($urandom_range(0, 1) == 0) begin
        #($urandom_range(2, 6)) reset = 1'b1;
        #($urandom_range(1, 8)) reset = 1'b0;
      end else begin
        #3 reset = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        #3 reset = 1'b0;
      end
    end
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
